// File: rtl/tff_counter_bank.sv
// WIDTH-bit T-FF register bank: raw toggle bank or modulo up/down counter with
// synchronous load, wrap/saturate limits, a terminal-event pulse and sticky overflow.
module tff_counter_bank #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_VAL  = 255,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t_vec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RstV = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] Zero = '0;
  localparam logic [WIDTH-1:0] One  = WIDTH'(1);

  localparam logic [1:0] ModeToggle = 2'b00;
  localparam logic [1:0] ModeUp     = 2'b01;
  localparam logic [1:0] ModeDown   = 2'b10;

  if (WIDTH < 1 || MAX_VAL < 1 || RST_VAL > MAX_VAL ||
      longint'(MAX_VAL) >= (longint'(1) << WIDTH)) begin : g_param_check
    $error("tff_counter_bank: illegal WIDTH/MAX_VAL/RST_VAL combination");
  end

  logic [WIDTH-1:0] q_next;
  logic             evt_next;
  logic             ovf_next;

  always_comb begin
    q_next   = q;
    evt_next = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      unique case (mode)
        ModeToggle: q_next = q ^ t_vec;
        ModeUp: begin
          if (q < MaxV) begin
            q_next = q + One;
          end else begin
            q_next   = SATURATE ? MaxV : Zero;
            evt_next = 1'b1;
          end
        end
        ModeDown: begin
          if (q == Zero) begin
            q_next   = SATURATE ? Zero : MaxV;
            evt_next = 1'b1;
          end else if (q > MaxV) begin
            // Out-of-range value (from load/toggle) snaps back to the ceiling silently.
            q_next = MaxV;
          end else begin
            q_next = q - One;
          end
        end
        default: q_next = q;
      endcase
    end
    ovf_next = (ovf & ~clr_ovf) | evt_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= RstV;
      evt <= 1'b0;
      ovf <= 1'b0;
    end else begin
      q   <= q_next;
      evt <= evt_next;
      ovf <= ovf_next;
    end
  end

endmodule

// File: tb/tb_tff_counter_bank.sv
// Bench for tff_counter_bank: a wrapping and a saturating instance share stimulus;
// table vectors, hand sequences and random stimulus against an integer model.
module tb_tff_counter_bank;

  localparam int MAXV = 9;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic [1:0] mode = 2'b01;
  logic [3:0] t_vec = '0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;
  logic       clr_ovf = 1'b0;
  logic [3:0] q_w, q_s;
  logic       evt_w, evt_s, ovf_w, ovf_s;

  int n_vec = 0;
  int n_bad = 0;

  // Model state, index 0 = wrapping instance, 1 = saturating instance.
  int mq[2];
  int mevt[2];
  int movf[2];

  tff_counter_bank #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0), .RST_VAL(0)) dut_w (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t_vec(t_vec), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .q(q_w), .evt(evt_w), .ovf(ovf_w)
  );

  tff_counter_bank #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1), .RST_VAL(0)) dut_s (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .t_vec(t_vec), .load(load),
    .load_val(load_val), .clr_ovf(clr_ovf), .q(q_s), .evt(evt_s), .ovf(ovf_s)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       load;
    logic [3:0] lv;
    logic       en;
    logic [1:0] mode;
    logic [3:0] t;
    logic       clr;
    int         eq;
    int         ee;
    int         eo;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic ld, input logic [3:0] lv,
                              input logic e, input logic [1:0] m, input logic [3:0] t,
                              input logic c, input int eq, input int ee, input int eo);
    vec_t v;
    v.rst = r; v.load = ld; v.lv = lv; v.en = e; v.mode = m; v.t = t; v.clr = c;
    v.eq = eq; v.ee = ee; v.eo = eo;
    tbl.push_back(v);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i] = 0; mevt[i] = 0; movf[i] = 0;
    end
  endfunction

  // Spec-level behaviour of one rising edge, plain integer arithmetic.
  function automatic void model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int nq = mq[i];
      int e = 0;
      if (load) nq = int'(load_val);
      else if (en && mode == 2'd0) nq = mq[i] ^ int'(t_vec);
      else if (en && mode == 2'd1) begin
        if (mq[i] < MAXV) nq = mq[i] + 1;
        else begin nq = (i == 1) ? MAXV : 0; e = 1; end
      end else if (en && mode == 2'd2) begin
        if (mq[i] == 0) begin nq = (i == 1) ? 0 : MAXV; e = 1; end
        else if (mq[i] > MAXV) nq = MAXV;
        else nq = mq[i] - 1;
      end
      mq[i] = nq % 16;
      mevt[i] = e;
      movf[i] = ((movf[i] != 0) && !clr_ovf) || (e != 0) ? 1 : 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("model_q_wrap", int'(q_w), mq[0]);
    check("model_evt_wrap", int'(evt_w), mevt[0]);
    check("model_ovf_wrap", int'(ovf_w), movf[0]);
    check("model_q_sat", int'(q_s), mq[1]);
    check("model_evt_sat", int'(evt_s), mevt[1]);
    check("model_ovf_sat", int'(ovf_s), movf[1]);
  endtask

  task automatic drive(input logic r, input logic ld, input logic [3:0] lv, input logic e,
                       input logic [1:0] m, input logic [3:0] t, input logic c);
    rst = r; load = ld; load_val = lv; en = e; mode = m; t_vec = t; clr_ovf = c;
  endtask

  initial begin
    model_reset();

    // Reset held while counting, then release.
    add(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) add(0, 0, 0, 1, 2'b01, 0, 0, i, 0, 0);
    // Toggle bank, then counting up from an out-of-range value wraps.
    add(1, 0, 0, 1, 2'b01, 0, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 4'b0101, 0, 5, 0, 0);
    add(0, 0, 0, 1, 2'b00, 4'b0101, 0, 0, 0, 0);
    add(0, 0, 0, 1, 2'b00, 4'b1111, 0, 15, 0, 0);
    add(0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 1);
    // Clear ovf, then a full wrap of the counter.
    add(0, 0, 0, 0, 2'b01, 0, 1, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(0, 0, 0, 1, 2'b01, 0, 0, i, 0, 0);
    add(0, 0, 0, 1, 2'b01, 0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 2'b01, 0, 0, 1, 0, 1);

    rst = 1'b1;
    #1;
    check("async_reset_q", int'(q_w), 0);
    check("async_reset_ovf", int'(ovf_w), 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].load, tbl[i].lv, tbl[i].en, tbl[i].mode, tbl[i].t,
            tbl[i].clr);
      step();
      check($sformatf("tbl%0d_q", i), int'(q_w), tbl[i].eq);
      check($sformatf("tbl%0d_evt", i), int'(evt_w), tbl[i].ee);
      check($sformatf("tbl%0d_ovf", i), int'(ovf_w), tbl[i].eo);
    end

    // Saturating count-down pinned at zero; set beats clear.
    drive(1, 0, 0, 0, 2'b11, 0, 0); step();
    drive(0, 1, 4'd1, 0, 2'b11, 0, 0); step();
    check("sat_load_q", int'(q_s), 1);
    drive(0, 0, 0, 1, 2'b10, 0, 0); step();
    check("sat_dn1_q", int'(q_s), 0); check("sat_dn1_evt", int'(evt_s), 0);
    step();
    check("sat_dn2_q", int'(q_s), 0); check("sat_dn2_evt", int'(evt_s), 1);
    step();
    check("sat_dn3_q", int'(q_s), 0); check("sat_dn3_evt", int'(evt_s), 1);
    check("sat_dn3_ovf", int'(ovf_s), 1);
    clr_ovf = 1'b1; step();
    check("sat_setwins_ovf", int'(ovf_s), 1); check("sat_setwins_evt", int'(evt_s), 1);
    en = 1'b0; step();
    check("sat_clr_ovf", int'(ovf_s), 0); check("sat_clr_evt", int'(evt_s), 0);

    // Load above the ceiling, count down snaps to MAX, load beats count.
    drive(0, 1, 4'hC, 0, 2'b10, 0, 1); step();
    check("load_c_q", int'(q_w), 12);
    drive(0, 0, 0, 1, 2'b10, 0, 0); step();
    check("snap_q", int'(q_w), 9); check("snap_evt", int'(evt_w), 0);
    drive(0, 1, 4'd3, 1, 2'b01, 0, 0); step();
    check("load_wins_q", int'(q_w), 3);

    // Mid-cycle async reset while counting with ovf set.
    drive(0, 1, 4'd9, 1, 2'b01, 0, 0); step();
    drive(0, 0, 0, 1, 2'b01, 0, 0); step();
    check("pre_rst_ovf", int'(ovf_w), 1);
    step();
    #1 rst = 1'b1;
    #1;
    check("midrst_q_wrap", int'(q_w), 0); check("midrst_ovf_wrap", int'(ovf_w), 0);
    check("midrst_q_sat", int'(q_s), 0); check("midrst_ovf_sat", int'(ovf_s), 0);
    #2 rst = 1'b0;
    model_reset();
    step(); check("resume1_q", int'(q_w), 1);
    step(); check("resume2_q", int'(q_w), 2);

    // Random stimulus against the model.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(49) == 0), ($urandom_range(7) == 0), 4'($urandom),
            ($urandom_range(3) != 0), 2'($urandom), 4'($urandom),
            ($urandom_range(3) == 0));
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
